// File: rtl/pulse_rate_monitor.sv
// Windowed event counter for the receive-domain pulse strobe, with threshold and overrun flags.
// Optional min/max tracking is compiled in when PULSE_RATE_MON_MINMAX_EN is defined.
module pulse_rate_monitor #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_reset,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             pulse_en,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             over_thresh,
  output logic             overrun,
  input  logic             overrun_clr,
`ifdef PULSE_RATE_MON_MINMAX_EN
  input  logic             minmax_clr,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e           state_q;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] evt_count_q;
  logic             evt_valid_q;
  logic             over_thresh_q;
  logic             overrun_q;
  logic             busy_q;

  logic [CNT_W-1:0] acc_d;
  logic             win_end_d;
  logic             slot_free_d;
  logic             load_d;
  logic             drop_d;

  // acc_d is the saturating count including this cycle's strobe, so it doubles as the window result.
  always_comb begin
    acc_d       = acc_q;
    if (pulse_en && (acc_q != {CNT_W{1'b1}}))
      acc_d = acc_q + CNT_W'(1);
    win_end_d   = (state_q == MEASURE) && enable && (win_cnt_q == (win_len_q - WIN_W'(1)));
    slot_free_d = !evt_valid_q || evt_ready;
    load_d      = win_end_d && slot_free_d;
    drop_d      = win_end_d && !slot_free_d;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state_q       <= IDLE;
      win_len_q     <= '0;
      win_cnt_q     <= '0;
      acc_q         <= '0;
      evt_count_q   <= '0;
      evt_valid_q   <= 1'b0;
      over_thresh_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && (win_len != '0)) begin
            win_len_q <= win_len;
            win_cnt_q <= '0;
            acc_q     <= '0;
            state_q   <= MEASURE;
            busy_q    <= 1'b1;
          end
        end
        MEASURE: begin
          if (!enable) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else if (win_end_d) begin
            // Back-to-back windows: the next one starts on the very next cycle.
            win_len_q <= win_len;
            win_cnt_q <= '0;
            acc_q     <= '0;
            if (win_len == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            acc_q     <= acc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (load_d) begin
        evt_count_q   <= acc_d;
        over_thresh_q <= (acc_d >= thresh);
        evt_valid_q   <= 1'b1;
      end else if (evt_valid_q && evt_ready) begin
        evt_valid_q <= 1'b0;
      end

      if (drop_d)
        overrun_q <= 1'b1;
      else if (overrun_clr)
        overrun_q <= 1'b0;
    end
  end

`ifdef PULSE_RATE_MON_MINMAX_EN
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;

  // A clear coinciding with a finished window restarts tracking from that window's result.
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      min_q <= {CNT_W{1'b1}};
      max_q <= '0;
    end else if (win_end_d) begin
      if (minmax_clr) begin
        min_q <= acc_d;
        max_q <= acc_d;
      end else begin
        if (acc_d < min_q) min_q <= acc_d;
        if (acc_d > max_q) max_q <= acc_d;
      end
    end else if (minmax_clr) begin
      min_q <= {CNT_W{1'b1}};
      max_q <= '0;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`endif

  assign evt_count   = evt_count_q;
  assign evt_valid   = evt_valid_q;
  assign over_thresh = over_thresh_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_rate_monitor.sv
// Scoreboard bench for pulse_rate_monitor: a window-level reference model predicts results,
// a negedge monitor compares them at each handshake along with busy/evt_valid/overrun.
module tb_pulse_rate_monitor;

  localparam int CNT_W = 4;
  localparam int WIN_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             rd_clk = 1'b0;
  logic             rd_reset;
  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] thresh;
  logic             pulse_en;
  logic [CNT_W-1:0] evt_count;
  logic             evt_valid;
  logic             evt_ready;
  logic             over_thresh;
  logic             overrun;
  logic             overrun_clr;
  logic             busy;

  pulse_rate_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .rd_clk      (rd_clk),
    .rd_reset    (rd_reset),
    .enable      (enable),
    .win_len     (win_len),
    .thresh      (thresh),
    .pulse_en    (pulse_en),
    .evt_count   (evt_count),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .over_thresh (over_thresh),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    int cnt;
    bit over;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  bit   checking = 0;

  // Window-level model: events are counted without bound and clamped only when the window closes.
  bit mIn, mValid, mOverrun;
  int mPos, mLen, mEvents;

  always @(posedge rd_clk) begin
    bit accepted, loaded, setOv;
    int res;
    exp_t e;
    if (rd_reset) begin
      mIn = 0; mValid = 0; mOverrun = 0; mPos = 0; mLen = 0; mEvents = 0;
      expQ.delete();
    end else begin
      accepted = mValid && evt_ready;
      loaded   = 0;
      setOv    = 0;
      if (!mIn) begin
        if (enable && win_len != 0) begin
          mIn = 1; mLen = int'(win_len); mPos = 0; mEvents = 0;
        end
      end else if (!enable) begin
        mIn = 0;
      end else begin
        mEvents += int'(pulse_en);
        mPos++;
        if (mPos == mLen) begin
          res = (mEvents > MAXC) ? MAXC : mEvents;
          if (!mValid || accepted) begin
            e.cnt  = res;
            e.over = (res >= int'(thresh));
            expQ.push_back(e);
            loaded = 1;
          end else begin
            setOv = 1;
          end
          if (win_len != 0) begin
            mLen = int'(win_len); mPos = 0; mEvents = 0;
          end else begin
            mIn = 0;
          end
        end
      end
      if (setOv) mOverrun = 1;
      else if (overrun_clr) mOverrun = 0;
      if (loaded) mValid = 1;
      else if (accepted) mValid = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops one expected result per handshake, and tracks control outputs every cycle.
  always @(negedge rd_clk) begin
    exp_t e;
    if (checking && !rd_reset) begin
      checkOutput("busy", int'(busy), int'(mIn));
      checkOutput("evt_valid", int'(evt_valid), int'(mValid));
      checkOutput("overrun", int'(overrun), int'(mOverrun));
      if (evt_valid && evt_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("evt_count", int'(evt_count), e.cnt);
          checkOutput("over_thresh", int'(over_thresh), int'(e.over));
        end
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit en, input int len, input bit p,
                               input bit rdy, input bit clr, input int th);
    rd_reset    = rst;
    enable      = en;
    win_len     = WIN_W'(len);
    pulse_en    = p;
    evt_ready   = rdy;
    overrun_clr = clr;
    thresh      = CNT_W'(th);
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checking = 1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_evt_count", int'(evt_count), 0);
    checkOutput("reset_evt_valid", int'(evt_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);

    // win_len=10 with strobes on window cycles 0, 3, 9; window starts one cycle after enable.
    for (int c = 0; c < 24; c++)
      applyStimulus(0, 1, 10, (c == 1 || c == 4 || c == 10), 1, 0, 2);
    applyStimulus(0, 0, 10, 0, 1, 0, 2);
    applyStimulus(0, 0, 10, 0, 1, 0, 2);

    // thresh=3: three strobes then two strobes in win_len=8 windows.
    for (int c = 0; c < 17; c++)
      applyStimulus(0, c < 16, 8, (c == 2 || c == 3 || c == 5 || c == 10 || c == 12), 1, 0, 3);
    applyStimulus(0, 0, 8, 0, 1, 0, 3);

    // Stalled consumer with win_len=4, then clear the sticky overrun and drain.
    for (int c = 0; c < 10; c++)
      applyStimulus(0, 1, 4, c[0], 0, 0, 1);
    applyStimulus(0, 0, 4, 0, 0, 1, 1);
    applyStimulus(0, 0, 4, 0, 1, 0, 1);
    applyStimulus(0, 0, 4, 0, 1, 0, 1);

    // Abort at cycle 5 of a win_len=20 window holding 4 strobes, then re-enable.
    for (int c = 0; c < 6; c++)
      applyStimulus(0, 1, 20, (c >= 1 && c <= 4), 1, 0, 5);
    applyStimulus(0, 0, 20, 0, 1, 0, 5);
    applyStimulus(0, 0, 20, 0, 1, 0, 5);
    for (int c = 0; c < 22; c++)
      applyStimulus(0, 1, 20, (c == 3), 1, 0, 5);
    applyStimulus(0, 0, 20, 0, 1, 0, 5);

    // Saturation: pulse held high over a 30-cycle window.
    for (int c = 0; c < 33; c++)
      applyStimulus(0, 1, 30, 1, 1, 0, 15);
    applyStimulus(0, 0, 30, 0, 1, 0, 15);
    applyStimulus(0, 0, 30, 0, 1, 0, 15);

    // win_len=0 with enable must keep the monitor idle.
    for (int c = 0; c < 5; c++)
      applyStimulus(0, 1, 0, 1, 1, 0, 0);
    checkOutput("zero_len_busy", int'(busy), 0);

    // Randomized traffic including zero thresholds, zero lengths, stalls and mid-run resets.
    for (int c = 0; c < 3000; c++)
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 24) != 0,
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));

    for (int c = 0; c < 6; c++)
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
